// File: rtl/mips_data_mem_pkg.sv
// Shared types and helpers for the byte-lane data memory responder.
package mips_mem_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} mem_state_t;

  localparam int WORD_BYTES = 4;
  localparam int LAT_CNT_W  = 4;

  typedef logic [7:0] byte_t;

  // Byte address of a lane within a word; lane 0 is the most significant byte (big-endian).
  function automatic logic [31:0] lane_addr(input logic [31:0] word_base, input logic [1:0] lane);
    return word_base + {30'd0, lane};
  endfunction

endpackage

// File: rtl/mips_mem_array.sv
// Byte storage with a synchronous 4-lane write port and a registered 4-lane read port.
// Stores echo their write data onto the read register so the response always reflects the access.
module mips_mem_array
  import mips_mem_pkg::*;
#(
  parameter int ADDR_BITS = 12
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en_i,
  input  logic                          we_i,
  input  logic [ADDR_BITS-3:0]          word_idx_i,
  input  byte_t [0:WORD_BYTES-1]        wdata_i,
  output byte_t [0:WORD_BYTES-1]        rdata_o
);

  byte_t                 mem_q [0:(1<<ADDR_BITS)-1];
  byte_t [0:WORD_BYTES-1] rdata_q;
  logic [ADDR_BITS-1:0]  lane_idx [0:WORD_BYTES-1];
  logic [31:0]           word_base;

  assign word_base = 32'({word_idx_i, 2'b00});

  always_comb begin
    for (int i = 0; i < WORD_BYTES; i++) begin
      lane_idx[i] = ADDR_BITS'(lane_addr(word_base, 2'(i)));
    end
  end

  // Contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (en_i && we_i) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        mem_q[lane_idx[i]] <= wdata_i[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (en_i) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        rdata_q[i] <= we_i ? wdata_i[i] : mem_q[lane_idx[i]];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mips_data_mem.sv
// Data-memory responder with req/ready handshake and LATENCY-cycle access; one access per LATENCY+1 cycles.
// Requests are sampled only in IDLE and nothing is queued. Optional macro: MEM_ALIGN_CHECK_EN (sticky misalignment error).
module mips_data_mem
  import mips_mem_pkg::*;
#(
  parameter int ADDR_BITS = 12,
  parameter int LATENCY   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_req,
  input  logic [31:0]            mem_addr,
  input  logic                   mem_write_en,
  input  byte_t [0:WORD_BYTES-1] mem_data_in,
  output byte_t [0:WORD_BYTES-1] mem_data_out,
  output logic                   mem_ready,
  output logic                   mem_busy,
  output logic                   mem_err
);

  mem_state_t             state_q, state_d;
  logic [LAT_CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic                   we_q, we_d;
  byte_t [0:WORD_BYTES-1] wdata_q, wdata_d;

  logic                   acc_en;
  logic [ADDR_BITS-1:0]   acc_addr;
  logic                   acc_we;
  byte_t [0:WORD_BYTES-1] acc_wdata;
  logic                   arr_en;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    acc_en    = 1'b0;
    acc_addr  = addr_q;
    acc_we    = we_q;
    acc_wdata = wdata_q;
    case (state_q)
      IDLE: begin
        // With LATENCY==1 the access happens on the accept edge, so it uses the live inputs.
        acc_addr  = mem_addr[ADDR_BITS-1:0];
        acc_we    = mem_write_en;
        acc_wdata = mem_data_in;
        if (mem_req) begin
          addr_d  = mem_addr[ADDR_BITS-1:0];
          we_d    = mem_write_en;
          wdata_d = mem_data_in;
          if (LATENCY == 1) begin
            acc_en  = 1'b1;
            state_d = RESP;
          end else begin
            cnt_d   = LAT_CNT_W'(LATENCY - 2);
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          acc_en  = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  logic err_q;

  assign arr_en = acc_en && !rst && (acc_addr[1:0] == 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (state_q == IDLE && mem_req && mem_addr[1:0] != 2'b00) begin
      err_q <= 1'b1;
    end
  end

  assign mem_err = err_q;
`else
  assign arr_en  = acc_en && !rst;
  assign mem_err = 1'b0;
`endif

  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_addr[31:ADDR_BITS], acc_addr[1:0]};

  mips_mem_array #(
    .ADDR_BITS (ADDR_BITS)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .en_i       (arr_en),
    .we_i       (acc_we),
    .word_idx_i (acc_addr[ADDR_BITS-1:2]),
    .wdata_i    (acc_wdata),
    .rdata_o    (mem_data_out)
  );

  assign mem_ready = (state_q == RESP);
  assign mem_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_mips_data_mem.sv
// Randomized bench for mips_data_mem against a byte-addressed reference memory (LATENCY=2 and LATENCY=1 instances).
module tb_mips_data_mem;
  import mips_mem_pkg::*;

  localparam int AB  = 12;
  localparam int LAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req, we, rdy, busy, err;
  logic [31:0] addr, din, dout;
  logic        req1, we1, rdy1, busy1, err1;
  logic [31:0] addr1, din1, dout1;

  mips_data_mem #(.ADDR_BITS(AB), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst), .mem_req(req), .mem_addr(addr), .mem_write_en(we),
    .mem_data_in(din), .mem_data_out(dout), .mem_ready(rdy), .mem_busy(busy), .mem_err(err)
  );

  mips_data_mem #(.ADDR_BITS(AB), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .mem_req(req1), .mem_addr(addr1), .mem_write_en(we1),
    .mem_data_in(din1), .mem_data_out(dout1), .mem_ready(rdy1), .mem_busy(busy1), .mem_err(err1)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: byte-addressed memory plus the last completed response and the sticky error.
  byte_t       mdl [int];
  logic [31:0] exp_last = 32'h0;
  logic        exp_err  = 1'b0;

  task automatic model_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                              output logic [31:0] e, output logic known);
    bit mis;
    int base;
`ifdef MEM_ALIGN_CHECK_EN
    mis = (a[1:0] != 2'b00);
`else
    mis = 1'b0;
`endif
    known = 1'b1;
    e     = exp_last;
    if (mis) begin
      exp_err = 1'b1;
    end else begin
      base = int'(a[AB-1:0]) & ~3;
      for (int i = 0; i < 4; i++) begin
        if (w) begin
          mdl[base + i] = d[31 - 8*i -: 8];
        end else if (mdl.exists(base + i)) begin
          e[31 - 8*i -: 8] = mdl[base + i];
        end else begin
          known = 1'b0;
        end
      end
      if (w) e = d;
      exp_last = e;
    end
  endtask

  task automatic op(input logic w, input logic [31:0] a, input logic [31:0] d,
                    input bit hold, input bit scramble, input string tag);
    logic [31:0] e;
    logic        known;
    @(negedge clk);
    req = 1'b1; addr = a; we = w; din = d;
    @(posedge clk);
    #1;
    if (!hold) req = 1'b0;
    if (scramble) begin
      addr = $urandom; din = $urandom; we = ~w;
    end
    model_access(w, a, d, e, known);
    for (int n = 1; n <= LAT; n++) begin
      @(negedge clk);
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_rdy"}, 32'(rdy), (n == LAT) ? 32'd1 : 32'd0);
    end
    if (known) check({tag, "_dat"}, dout, e);
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    @(negedge clk);
    check({tag, "_idle_rdy"}, 32'(rdy), 32'd0);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    req = 1'b0;
    if (hold) begin
      @(negedge clk);
      check({tag, "_no_reaccept"}, 32'(busy), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1;
    req = 1'b0; we = 1'b0; addr = '0; din = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; din1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_dout", dout, 32'h0);
    check("rst_rdy", 32'(rdy), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_dout1", dout1, 32'h0);
    rst = 1'b0;

    op(1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, "st10");
    op(1'b0, 32'h10, 32'h0, 1'b0, 1'b0, "ld10");
    op(1'b1, 32'h1000_0020, 32'h11223344, 1'b0, 1'b0, "st_wrap");
    op(1'b0, 32'h20, 32'h0, 1'b0, 1'b0, "ld_wrap");
    op(1'b1, 32'h30, 32'hCAFEF00D, 1'b1, 1'b1, "st_hold");
    op(1'b0, 32'h30, 32'h0, 1'b1, 1'b1, "ld_hold");

    // Reset while a store is in flight: the store must not land.
    op(1'b1, 32'h40, 32'h0, 1'b0, 1'b0, "st40_zero");
    @(negedge clk);
    req = 1'b1; addr = 32'h40; we = 1'b1; din = 32'hFFFFFFFF;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy_after", 32'(busy), 32'd0);
    check("abort_rdy", 32'(rdy), 32'd0);
    check("abort_dout", dout, 32'h0);
    rst = 1'b0;
    exp_last = 32'h0;
    exp_err  = 1'b0;

    // Reset and request together: reset wins.
    @(negedge clk);
    rst = 1'b1; req = 1'b1; addr = 32'h40; we = 1'b1; din = 32'hFFFFFFFF;
    @(negedge clk);
    check("rst_req_busy", 32'(busy), 32'd0);
    rst = 1'b0; req = 1'b0;
    op(1'b0, 32'h40, 32'h0, 1'b0, 1'b0, "ld40");

    op(1'b1, 32'h22, 32'hA5A5A5A5, 1'b0, 1'b0, "st_mis");
    op(1'b0, 32'h20, 32'h0, 1'b0, 1'b0, "ld_after_mis");

    for (int w = 0; w < 16; w++) begin
      op(1'b1, {$urandom_range(0, 255), 24'h0} | (32'h100 + 32'(4*w)), $urandom, 1'b0, 1'b0, "rnd_init");
    end
    for (int k = 0; k < 40; k++) begin
      logic [31:0] a;
      a = {20'($urandom), 12'h100 + 12'(4*$urandom_range(0, 15))};
      if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
      op(1'($urandom), a, $urandom, 1'($urandom), 1'($urandom), "rnd");
    end

    // LATENCY=1: back-to-back with mem_req held high.
    @(negedge clk);
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h0; din1 = 32'hA1A2A3A4;
    @(negedge clk);
    check("l1_rdy_a", 32'(rdy1), 32'd1);
    check("l1_busy_a", 32'(busy1), 32'd1);
    check("l1_dat_a", dout1, 32'hA1A2A3A4);
    addr1 = 32'h4; din1 = 32'hB1B2B3B4;
    @(negedge clk);
    check("l1_idle_rdy", 32'(rdy1), 32'd0);
    check("l1_idle_busy", 32'(busy1), 32'd0);
    @(negedge clk);
    check("l1_rdy_b", 32'(rdy1), 32'd1);
    check("l1_dat_b", dout1, 32'hB1B2B3B4);
    req1 = 1'b0;
    @(negedge clk);
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h4;
    @(negedge clk);
    check("l1_ld4_rdy", 32'(rdy1), 32'd1);
    check("l1_ld4", dout1, 32'hB1B2B3B4);
    req1 = 1'b0;
    @(negedge clk);
    req1 = 1'b1; addr1 = 32'h0;
    @(negedge clk);
    check("l1_ld0", dout1, 32'hA1A2A3A4);
    req1 = 1'b0;
    @(negedge clk);
    check("l1_err", 32'(err1), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_data_mem.md
Name: mips_data_mem

Overview:
- Byte-lane data-memory responder; the memory-side end of the core's load/store port (mem_addr, mem_data_in[0:3], mem_data_out[0:3], mem_write_en).
- Adds a request/ready handshake with configurable access latency, so the core can be stalled on slow memory.
- Big-endian word access: lane 0 is the byte at the word address, matching MIPS byte order.

Parameters:
- ADDR_BITS, 12, byte-address width actually decoded; memory size is 2^ADDR_BITS bytes.
- LATENCY, 2, cycles from request acceptance to mem_ready; legal range 1..16.

Ports:
- clk  input  1  clock, all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- mem_req  input  1  access request; sampled only in IDLE.
- mem_addr  input  32  byte address of the access.
- mem_write_en  input  1  1 = store, 0 = load; sampled with mem_req.
- mem_data_in  input  8 x [0:3]  store data per byte lane; lane i goes to byte mem_addr+i.
- mem_data_out  output  8 x [0:3]  load data per byte lane; lane i is from byte mem_addr+i.
- mem_ready  output  1  one-cycle pulse; access complete and mem_data_out valid.
- mem_busy  output  1  high whenever state is not IDLE.
- mem_err  output  1  sticky misalignment flag (MEM_ALIGN_CHECK_EN only; else tied 0).

Behaviour:
- Reset values:
  - state = IDLE; mem_ready = 0; mem_busy = 0; mem_err = 0; mem_data_out lanes = 8'h00; latency counter = 0.
  - Memory contents are not cleared by reset.
- FSM states: IDLE, BUSY, RESP.
- IDLE with mem_req = 1 at an edge (accept):
  - Capture mem_addr, mem_write_en and all four mem_data_in lanes into request registers.
  - LATENCY == 1: perform the access at this edge and go to RESP.
  - LATENCY > 1: load counter with LATENCY-2 and go to BUSY.
- BUSY:
  - Counter nonzero: decrement it and stay in BUSY.
  - Counter zero: perform the access at this edge and go to RESP.
- RESP: mem_ready = 1 for exactly this one cycle, then go to IDLE unconditionally.
- Latency and throughput:
  - mem_ready is high in the cycle exactly LATENCY edges after the accept edge.
  - mem_req is ignored while BUSY or RESP; nothing is queued.
  - The earliest next accept is at the edge ending the RESP cycle's successor IDLE cycle, giving a throughput of one access per LATENCY+1 cycles.
- Access semantics:
  - Word index = captured addr[ADDR_BITS-1:2]. Address bits at and above ADDR_BITS are ignored, so addresses wrap modulo 2^ADDR_BITS.
  - Store: the four captured lanes are written to bytes word_base+0..3. mem_data_out is loaded with the written data.
  - Load: mem_data_out is loaded with bytes word_base+0..3.
  - mem_data_out holds its value until the next completed access.
- Request registers isolate the access: inputs changing after the accept edge have no effect on it.
- Reset mid-operation (BUSY or RESP): return to IDLE and drop the request. A pending store is not performed; a store already performed stays in memory.
- Simultaneous rst and mem_req: reset wins and the request is not accepted.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined:
  - An accepted request with addr[1:0] != 0 performs no memory read or write.
  - The FSM still runs the full latency; mem_data_out is unchanged and mem_ready pulses normally.
  - mem_err is set at the accept edge and stays set until rst.
- Undefined: addr[1:0] is ignored (access rounds down to the word) and mem_err is constant 0.

Decomposition:
- Package mips_mem_pkg:
  - enum mem_state_t {IDLE, BUSY, RESP}
  - WORD_BYTES = 4
  - LAT_CNT_W = 4
  - byte_t typedef (logic [7:0])
  - function lane_addr(word_base, lane)
- Sub-module mips_mem_array:
  - Contains the byte storage (2^ADDR_BITS bytes), a synchronous 4-lane write port and a 4-lane read port.
  - Read data is registered on the access edge.
  - Top level holds the FSM, counter and request registers.

Test Plan:
- LATENCY=2: store addr 0x10, lanes {DE,AD,BE,EF}; then load 0x10 → mem_ready 2 cycles after each accept, load returns lanes {DE,AD,BE,EF}, mem_busy high 2 cycles per access.
- LATENCY=1: back-to-back mem_req held high for stores to 0x0 and 0x4 → accepts every 2 cycles; readback of 0x4 returns the second store's data.
- Hold mem_req through BUSY while mem_addr and mem_data_in change after accept → only the first request completes, with the originally captured data; no second mem_ready until re-accepted from IDLE.
- ADDR_BITS=12: store 0x1000_0020 with {11,22,33,44}, then load 0x020 → returns {11,22,33,44} (wrap).
- Assert rst in BUSY of a store to 0x40 holding 0x00000000 with data {FF,FF,FF,FF} → IDLE next cycle, no mem_ready; a later load of 0x40 returns {00,00,00,00}.
- With MEM_ALIGN_CHECK_EN: store 0x22 → mem_ready pulses, mem_err goes to 1 and stays set; a load of 0x20 shows the word unchanged. Without the macro: store 0x22 writes word 0x20 and mem_err stays 0.
